// File: rtl/sdram_prefetch_buffer_if.sv
// sdram_prefetch_buffer_if: Wishbone slave, sdram_controller request/response and statistics signals
interface sdram_prefetch_buffer_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic                  wbs_stb_i;
  logic                  wbs_cyc_i;
  logic                  wbs_we_i;
  logic [DATA_W/8-1:0]   wbs_sel_i;
  logic [DATA_W-1:0]     wbs_dat_i;
  logic [31:0]           wbs_adr_i;
  logic                  wbs_ack_o;
  logic [DATA_W-1:0]     wbs_dat_o;
  logic                  ctrl_in_valid;
  logic                  ctrl_rw;
  logic [ADDR_W-1:0]     ctrl_addr;
  logic [DATA_W-1:0]     ctrl_data_in;
  logic [DATA_W/8-1:0]   ctrl_mask;
  logic                  ctrl_busy;
  logic [DATA_W-1:0]     ctrl_data_out;
  logic                  ctrl_out_valid;
  logic [CNT_W-1:0]      hit_cnt;
  logic [CNT_W-1:0]      miss_cnt;
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o,
    output ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_data_in, ctrl_mask,
    input  ctrl_busy, ctrl_data_out, ctrl_out_valid,
    output hit_cnt, miss_cnt
  );
  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o,
    input  ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_data_in, ctrl_mask,
    output ctrl_busy, ctrl_data_out, ctrl_out_valid,
    input  hit_cnt, miss_cnt
  );
endinterface

// File: rtl/sdram_prefetch_buffer.sv
// sdram_prefetch_buffer: line-based read prefetch buffer with write-through between Wishbone and sdram_controller
module sdram_prefetch_buffer #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  sdram_prefetch_buffer_if.slave bus
);
  localparam int LW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;
  localparam int TW = ADDR_W - LW - 2;
  typedef enum logic [1:0] {IDLE, FILL, WR} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] buf_q [DEPTH];
  logic [DATA_W-1:0] buf_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q, tag_d;
  logic line_q, line_d;
  logic [LW:0] issue_q, issue_d, fill_q, fill_d;
  logic ack_q, ack_d, pend_q, pend_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic req, rd, hit, fwd, wvalid, unused_adr;
  logic [TW-1:0] tag;
  logic [LW-1:0] word, fword;
  assign req = bus.wbs_stb_i & bus.wbs_cyc_i & ~ack_q;
  assign rd = req & ~bus.wbs_we_i;
  assign tag = bus.wbs_adr_i[ADDR_W-1:LW+2];
  assign word = bus.wbs_adr_i[LW+1:2];
  assign hit = line_q & (tag == tag_q);
  assign fword = fill_q[LW-1:0];
  // returning fill word is forwarded so a waiting read acks the cycle after it arrives
  assign fwd = (state_q == FILL) & bus.ctrl_out_valid & ~fill_q[LW];
  assign wvalid = valid_q[word] | (fwd & (fword == word));
  assign unused_adr = ^{bus.wbs_adr_i[31:ADDR_W], bus.wbs_adr_i[1:0]};
  assign bus.ctrl_in_valid = (state_q == FILL) ? ~issue_q[LW] : (state_q == WR);
  assign bus.ctrl_rw = (state_q == WR);
  assign bus.ctrl_addr = (state_q == FILL) ? {tag_q, issue_q[LW-1:0], 2'b00} :
                         (state_q == WR) ? {bus.wbs_adr_i[ADDR_W-1:2], 2'b00} : '0;
  assign bus.ctrl_data_in = (state_q == WR) ? bus.wbs_dat_i : '0;
  assign bus.ctrl_mask = (state_q == WR) ? bus.wbs_sel_i : '0;
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
  assign bus.hit_cnt = hit_q;
  assign bus.miss_cnt = miss_q;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return c + {{(CNT_W-1){1'b0}}, ~&c};
  endfunction
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    valid_d = valid_q;
    tag_d = tag_q;
    line_d = line_q;
    issue_d = issue_q;
    fill_d = fill_q;
    ack_d = 1'b0;
    dat_d = dat_q;
    hit_d = hit_q;
    miss_d = miss_q;
    if (fwd) begin
      buf_d[fword] = bus.ctrl_data_out;
      valid_d[fword] = 1'b1;
      fill_d = fill_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (rd && hit && valid_q[word]) begin
          ack_d = 1'b1;
          dat_d = buf_q[word];
          hit_d = sat_inc(hit_q);
        end else if (rd) begin
          tag_d = tag;
          line_d = 1'b1;
          valid_d = '0;
          issue_d = '0;
          fill_d = '0;
          miss_d = sat_inc(miss_q);
          state_d = FILL;
        end else if (req) state_d = WR;
      end
      FILL: begin
        if (bus.ctrl_in_valid && !bus.ctrl_busy) issue_d = issue_q + 1'b1;
        // only a request whose word was already resident on arrival counts as a hit
        if (rd && hit && wvalid) begin
          ack_d = 1'b1;
          dat_d = valid_q[word] ? buf_q[word] : bus.ctrl_data_out;
          hit_d = (!pend_q && valid_q[word]) ? sat_inc(hit_q) : hit_q;
        end
        if (fill_q[LW]) state_d = IDLE;
      end
      WR: begin
        if (!bus.ctrl_busy) begin
          ack_d = 1'b1;
          state_d = IDLE;
          if (hit) for (int i = 0; i < NB; i++) if (bus.wbs_sel_i[i]) buf_d[word][8*i +: 8] = bus.wbs_dat_i[8*i +: 8];
        end
      end
      default: state_d = IDLE;
    endcase
    pend_d = req & ~ack_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q <= '{default: '0};
      valid_q <= '0;
      tag_q <= '0;
      line_q <= 1'b0;
      issue_q <= '0;
      fill_q <= '0;
      ack_q <= 1'b0;
      pend_q <= 1'b0;
      dat_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      valid_q <= valid_d;
      tag_q <= tag_d;
      line_q <= line_d;
      issue_q <= issue_d;
      fill_q <= fill_d;
      ack_q <= ack_d;
      pend_q <= pend_d;
      dat_q <= dat_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  end
endmodule
